// File: rtl/phase_monitor.sv
// phase_monitor: receive side of the CPU phase-strobe interface.
// Tracks the eight-phase strobe frame from the clock sequencer. Reports the
// current phase, counts completed instruction frames, and latches the first
// sequencing fault until software clears it.
module phase_monitor #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             ena,
    input  logic             pc,
    input  logic             opram,
    input  logic             mem,
    input  logic             acc,
    input  logic             alu,
    input  logic             out,
    input  logic             clr_err,
    output logic             locked,
    output logic [2:0]       phase,
    output logic             phase_valid,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [5:0]       err_pattern,
    output logic [2:0]       err_phase
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_ERROR  = 2'd2
    } state_e;

    localparam logic [5:0] PAT_START = 6'b100000;
    localparam logic [1:0] CODE_MISMATCH = 2'b01;
    localparam logic [1:0] CODE_ILLEGAL  = 2'b10;

    state_e           state_q, state_d;
    logic             ena_q;
    logic [2:0]       exp_q, exp_d;
    logic [2:0]       phase_q, phase_d;
    logic             pv_q, pv_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic [5:0]       epat_q, epat_d;
    logic [2:0]       eph_q, eph_d;

    logic [5:0] vec;
    logic       fresh;
    logic       legal;
    logic       match;

    // Strobe pattern the sequencer drives for each phase index.
    function automatic logic [5:0] phasePattern(input logic [2:0] idx);
        logic [5:0] p;
        case (idx)
            3'd0:    p = 6'b100000;
            3'd1:    p = 6'b010000;
            3'd2:    p = 6'b001100;
            3'd3:    p = 6'b000010;
            3'd4:    p = 6'b001100;
            3'd7:    p = 6'b000001;
            default: p = 6'b000000;
        endcase
        return p;
    endfunction

    // Any vector the sequencer can ever produce, independent of position.
    function automatic logic isLegal(input logic [5:0] v);
        logic ok;
        case (v)
            6'b100000, 6'b010000, 6'b001100,
            6'b000010, 6'b000000, 6'b000001: ok = 1'b1;
            default:                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign vec   = {pc, opram, mem, acc, alu, out};
    assign fresh = ena_q;
    assign legal = isLegal(vec);
    assign match = (vec == phasePattern(exp_q));

    // State, enable history and all registered outputs.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q <= ST_HUNT;
            ena_q   <= 1'b0;
            exp_q   <= 3'd0;
            phase_q <= 3'd0;
            pv_q    <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            epat_q  <= 6'b000000;
            eph_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            ena_q   <= ena;
            exp_q   <= exp_d;
            phase_q <= phase_d;
            pv_q    <= pv_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            code_q  <= code_d;
            epat_q  <= epat_d;
            eph_q   <= eph_d;
        end
    end

    // Next state: lock on a fresh start pattern, drop to error on any bad fresh vector.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HUNT: begin
                if (fresh && (vec == PAT_START)) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (fresh && (!legal || !match)) begin
                    state_d = ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (clr_err) begin
                    state_d = ST_HUNT;
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    // Phase tracking, frame counting and fault capture; stale edges leave everything held.
    always_comb begin
        exp_d   = exp_q;
        phase_d = phase_q;
        pv_d    = 1'b0;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        err_d   = err_q;
        code_d  = code_q;
        epat_d  = epat_q;
        eph_d   = eph_q;
        case (state_q)
            ST_HUNT: begin
                if (fresh && (vec == PAT_START)) begin
                    phase_d = 3'd0;
                    pv_d    = 1'b1;
                    exp_d   = 3'd1;
                end
            end
            ST_LOCKED: begin
                if (fresh) begin
                    if (!legal || !match) begin
                        err_d  = 1'b1;
                        code_d = legal ? CODE_MISMATCH : CODE_ILLEGAL;
                        epat_d = vec;
                        eph_d  = exp_q;
                    end else begin
                        phase_d = exp_q;
                        pv_d    = 1'b1;
                        exp_d   = exp_q + 3'd1;
                        if (exp_q == 3'd7) begin
                            done_d = 1'b1;
                            cnt_d  = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_ERROR: begin
                if (clr_err) begin
                    err_d  = 1'b0;
                    code_d = 2'b00;
                    epat_d = 6'b000000;
                    eph_d  = 3'd0;
                end
            end
            default: begin
                exp_d = 3'd0;
            end
        endcase
    end

    // Output mapping; locked follows the registered state directly.
    always_comb begin
        locked      = (state_q == ST_LOCKED);
        phase       = phase_q;
        phase_valid = pv_q;
        instr_done  = done_q;
        instr_count = cnt_q;
        err         = err_q;
        err_code    = code_q;
        err_pattern = epat_q;
        err_phase   = eph_q;
    end

endmodule

// File: doc/phase_monitor.md
Name: phase_monitor

Overview:
- Receiving end of the CPU phase-strobe interface: consumes the six one-hot phase strobes produced by the clock sequencer.
- Checks that the strobes follow the legal 8-phase frame and reconstructs the current phase index.
- Counts completed instruction frames and flags sequencing faults with sticky diagnostics.
- Sits beside the sequencer, feeding the debug/status block and the halt logic.

Parameters:
- CNT_W, 16, width of the instruction frame counter (wraps).

Ports:
- clk_in  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- ena  input  1  the same enable that drives the sequencer.
- pc  input  1  phase strobe.
- opram  input  1  phase strobe.
- mem  input  1  phase strobe.
- acc  input  1  phase strobe.
- alu  input  1  phase strobe.
- out  input  1  phase strobe.
- clr_err  input  1  single-cycle pulse; clears the error state.
- locked  output  1  frame alignment established.
- phase  output  3  index of the last matched phase, 0..7.
- phase_valid  output  1  one-cycle pulse on each matched phase.
- instr_done  output  1  one-cycle pulse when phase 7 (out) matches.
- instr_count  output  CNT_W  completed frames since reset.
- err  output  1  sticky fault flag.
- err_code  output  2  01 = sequence mismatch, 10 = illegal pattern.
- err_pattern  output  6  strobe vector captured at the fault.
- err_phase  output  3  expected phase index at the fault.

Behaviour:
- Strobe vector V = {pc,opram,mem,acc,alu,out}.
- Frame, phases 0..7:
  - 0: 100000
  - 1: 010000
  - 2: 001100
  - 3: 000010
  - 4: 001100
  - 5: 000000
  - 6: 000000
  - 7: 000001
  - After phase 7 the frame repeats from phase 0.
- Legal set: 100000, 010000, 001100, 000010, 000000, 000001. Any other V is illegal.
- Freshness:
  - ena is registered into ena_q.
  - A rising edge with ena_q=1 presents a fresh V, since the sequencer updated its strobes on the previous edge.
  - Edges with ena_q=0 are ignored entirely: no checks, no pulses, and outputs hold.
- Reset (rst low, async): state HUNT, ena_q=0, and all outputs 0 (locked, phase, phase_valid, instr_done, instr_count, err, err_code, err_pattern, err_phase).
- FSM, states HUNT / LOCKED / ERROR:
  - HUNT:
    - Fresh V=100000 -> LOCKED; phase=0; phase_valid pulses; expected phase becomes 1.
    - Any other fresh V, including illegal ones, is ignored with no error.
  - LOCKED:
    - Fresh V checked against the expected phase E.
    - Illegal V -> ERROR, err_code=10. Illegal takes precedence over mismatch.
    - Legal V that differs from E's pattern -> ERROR, err_code=01.
    - Match -> phase=E, phase_valid pulses, E advances to (E+1) mod 8.
    - Match at E=7 -> instr_done pulses and instr_count increments, wrapping from all-ones to 0.
  - On entering ERROR:
    - err=1; err_pattern=V; err_phase=E.
    - locked=0; phase holds its last value; no pulses.
    - err_code is set as listed under LOCKED.
  - ERROR:
    - Holds until clr_err=1.
    - clr_err -> HUNT; err, err_code, err_pattern and err_phase clear to 0.
    - Any fresh V on the same edge as clr_err is ignored.
    - instr_count is not cleared.
  - clr_err in HUNT or LOCKED has no effect.
- locked is 1 exactly while the state is LOCKED, registered, and updates on the same edge as the state.
- Latency: V is registered on the edge it becomes fresh; pulses are high for exactly one cycle following that edge.
- Sequencer timing: with ena held at 1 from reset release, the sequencer drives pc after edge 1, so the monitor locks on edge 2.
- Phases 5 and 6 are identical (000000) and are disambiguated only by E.
- Reset mid-frame: immediate return to HUNT. Relock needs the next fresh 100000.

Test Plan:
- ena=1 continuously, sequencer model for 3 frames -> locked=1 after edge 2; phase steps 0..7 repeatedly; instr_done pulses 3 times; instr_count=3; err=0.
- ena toggled 1,0,0,1,... during frames -> no pulses on stalled edges, phase holds, and frames still count correctly with no error.
- Replace phase 3 (000010) with 000000 -> err=1, err_code=01, err_pattern=000000, err_phase=3, locked=0.
- Drive 110000 at phase 1 -> err_code=10, err_pattern=110000, err_phase=1.
- clr_err pulse in ERROR with a fresh 100000 on the same edge -> HUNT; relock only on the next frame's 100000; instr_count unchanged.
- CNT_W=4, 17 frames -> instr_count=1 after wrap. rst asserted mid-phase 4 -> all outputs 0 asynchronously, and relock after release.
